// File: rtl/pulse_qualifier.sv
// pulse_qualifier: per-channel hysteretic glitch filter with rise/fall strobes and pulse-width measurement.
// Define PULSEQ_SYNC_EN to insert a 2-flop synchronizer in front of every channel.
module pulse_qualifier #(
  parameter int CH = 4,
  parameter int CW = 8,
  parameter int MIN_HIGH = 6,
  parameter int MIN_LOW = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [CH-1:0]    signal,
  output logic [CH-1:0]    clean,
  output logic [CH-1:0]    rise,
  output logic [CH-1:0]    fall,
  output logic [CH-1:0]    width_vld,
  output logic [CH*CW-1:0] width_out
);
  typedef enum logic [1:0] {LOW, QUAL_H, HIGH, QUAL_L} state_t;
  localparam logic [CW-1:0] QH = CW'(MIN_HIGH - 1);
  localparam logic [CW-1:0] QL = CW'(MIN_LOW - 1);
  localparam logic [CW-1:0] WMAX = '1;
  logic [CH-1:0] s;
`ifdef PULSEQ_SYNC_EN
  logic [CH-1:0] s1;
  always_ff @(posedge clk or posedge rst)
    if (rst) {s, s1} <= '0;
    else {s, s1} <= {s1, signal};
`else
  assign s = signal;
`endif
  for (genvar i = 0; i < CH; i++) begin : g_ch
    state_t st, st_n;
    logic [CW-1:0] q, q_n, w, w_n, wo;
    logic c, c_n, r, f;
    always_comb begin
      st_n = st;
      case (st)
        LOW:    st_n = s[i] ? (MIN_HIGH == 1 ? HIGH : QUAL_H) : LOW;
        QUAL_H: st_n = !s[i] ? LOW : (q == QH ? HIGH : QUAL_H);
        HIGH:   st_n = !s[i] ? (MIN_LOW == 1 ? LOW : QUAL_L) : HIGH;
        QUAL_L: st_n = s[i] ? HIGH : (q == QL ? LOW : QUAL_L);
        default: st_n = LOW;
      endcase
      q_n = (st_n == QUAL_H || st_n == QUAL_L) ? (st_n == st ? q + 1'b1 : CW'(1)) : '0;
      c_n = st_n == HIGH || st_n == QUAL_L;
      // A return from QUAL_L keeps counting; only a fresh qualification restarts the width.
      w_n = (c_n && !c) ? CW'(1) : (c_n && w != WMAX) ? w + 1'b1 : w;
    end
    always_ff @(posedge clk or posedge rst)
      if (rst) begin
        st <= LOW;
        q <= '0;
        w <= '0;
        c <= 1'b0;
        r <= 1'b0;
        f <= 1'b0;
        wo <= '0;
      end else begin
        st <= st_n;
        q <= q_n;
        w <= w_n;
        c <= c_n;
        r <= c_n && !c;
        f <= !c_n && c;
        wo <= (!c_n && c) ? w : wo;
      end
    assign clean[i] = c;
    assign rise[i] = r;
    assign fall[i] = f;
    assign width_vld[i] = f;
    assign width_out[i*CW +: CW] = wo;
  end
endmodule

// File: tb/tb_pulse_qualifier.sv
// tb_pulse_qualifier: directed and randomized checks against a run-length reference model.
// The model follows PULSEQ_SYNC_EN when the bench is built with it.
module tb_pulse_qualifier;
  localparam int CH = 4, CW = 8, MH = 6, ML = 6;
`ifdef PULSEQ_SYNC_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 0;
`endif
  logic clk = 0, rst = 1;
  logic [CH-1:0] sig = '0;
  logic [CH-1:0] clean, rise, fall, width_vld;
  logic [CH*CW-1:0] width_out;
  int nchk = 0, nfail = 0;
  int ones [CH], zeros [CH], hi [CH];
  logic [CW-1:0] m_wo [CH];
  logic [CH-1:0] m_clean, m_rise, m_fall, p1, p2;

  pulse_qualifier #(.CH(CH), .CW(CW), .MIN_HIGH(MH), .MIN_LOW(ML)) dut (
    .clk(clk), .rst(rst), .signal(sig), .clean(clean), .rise(rise),
    .fall(fall), .width_vld(width_vld), .width_out(width_out)
  );

  always #5 clk = ~clk;

  task automatic model_reset();
    for (int i = 0; i < CH; i++) begin
      ones[i] = 0;
      zeros[i] = 0;
      hi[i] = 0;
      m_wo[i] = '0;
    end
    {m_clean, m_rise, m_fall, p1, p2} = '0;
  endtask

  // clean follows the most recent qualifying run: MH ones sets it, ML zeros clears it.
  task automatic model_edge();
    logic [CH-1:0] s;
    logic nc;
`ifdef PULSEQ_SYNC_EN
    s = p2;
    p2 = p1;
    p1 = sig;
`else
    s = sig;
`endif
    for (int i = 0; i < CH; i++) begin
      ones[i] = s[i] ? ones[i] + 1 : 0;
      zeros[i] = s[i] ? 0 : zeros[i] + 1;
      nc = ones[i] >= MH ? 1'b1 : zeros[i] >= ML ? 1'b0 : m_clean[i];
      m_rise[i] = nc & ~m_clean[i];
      m_fall[i] = ~nc & m_clean[i];
      if (m_rise[i]) hi[i] = 1;
      else if (nc && hi[i] < 255) hi[i]++;
      if (m_fall[i]) m_wo[i] = CW'(hi[i]);
      m_clean[i] = nc;
    end
  endtask

  function automatic logic [5*CH+CH*CW-1-CH:0] exp_vec();
    logic [CH*CW-1:0] pw;
    for (int i = 0; i < CH; i++) pw[i*CW +: CW] = m_wo[i];
    return {m_clean, m_rise, m_fall, m_fall, pw};
  endfunction

  task automatic step(input logic [CH-1:0] v);
    sig = v;
    @(posedge clk);
    if (rst) model_reset();
    else model_edge();
    #1;
  endtask

  task automatic test_reset();
    rst = 1;
    model_reset();
    sig = '0;
    repeat (2) @(posedge clk);
    #1;
    nchk++;
    if ({clean, rise, fall, width_vld, width_out} !== '0) begin
      nfail++;
      $display("FAIL reset: got %h required 0", {clean, rise, fall, width_vld, width_out});
    end
    rst = 0;
  endtask

  task automatic test_short();
    int seen = 0;
    for (int n = 0; n < 13; n++) begin
      step(n < 5 ? 4'b0001 : 4'b0000);
      seen += int'(rise[0] | fall[0] | width_vld[0] | clean[0]);
      nchk++;
      if ({clean, rise, fall, width_vld, width_out} !== exp_vec()) begin
        nfail++;
        $display("FAIL short cyc %0d: got %h required %h", n, {clean, rise, fall, width_vld, width_out}, exp_vec());
      end
    end
    nchk++;
    if (seen != 0) begin
      nfail++;
      $display("FAIL short_activity: got %0d required 0", seen);
    end
  endtask

  task automatic test_pulse();
    int rise_at = -1, fall_at = -1;
    logic [CW-1:0] w = '0;
    for (int n = 0; n < 20; n++) begin
      step(n < 10 ? 4'b0001 : 4'b0000);
      if (rise[0] && rise_at < 0) rise_at = n;
      if (fall[0] && fall_at < 0) begin
        fall_at = n;
        w = width_vld[0] ? width_out[7:0] : 8'hxx;
      end
      nchk++;
      if ({clean, rise, fall, width_vld, width_out} !== exp_vec()) begin
        nfail++;
        $display("FAIL pulse cyc %0d: got %h required %h", n, {clean, rise, fall, width_vld, width_out}, exp_vec());
      end
    end
    nchk += 3;
    if (rise_at != 5 + LAT) begin
      nfail++;
      $display("FAIL pulse_rise_cycle: got %0d required %0d", rise_at, 5 + LAT);
    end
    if (fall_at != 15 + LAT) begin
      nfail++;
      $display("FAIL pulse_fall_cycle: got %0d required %0d", fall_at, 15 + LAT);
    end
    if (w !== 8'd10) begin
      nfail++;
      $display("FAIL pulse_width: got %0d required 10", w);
    end
  endtask

  task automatic test_glitch();
    int nr = 0, nf = 0;
    logic [CW-1:0] w = '0;
    for (int n = 0; n < 25; n++) begin
      step((n < 8 || (n >= 11 && n < 15)) ? 4'b0010 : 4'b0000);
      nr += int'(rise[1]);
      nf += int'(fall[1]);
      if (width_vld[1]) w = width_out[15:8];
      nchk++;
      if ({clean, rise, fall, width_vld, width_out} !== exp_vec()) begin
        nfail++;
        $display("FAIL glitch cyc %0d: got %h required %h", n, {clean, rise, fall, width_vld, width_out}, exp_vec());
      end
    end
    nchk++;
    if (nr != 1 || nf != 1 || w !== 8'd15) begin
      nfail++;
      $display("FAIL glitch_summary: got rises=%0d falls=%0d width=%0d required 1 1 15", nr, nf, w);
    end
  endtask

  task automatic test_saturate();
    int v2 = 0, v3 = 0;
    logic [CW-1:0] w2 = '0, w3 = '0;
    for (int n = 0; n < 315; n++) begin
      step({n < 10 ? 1'b1 : 1'b0, n < 300 ? 1'b1 : 1'b0, 2'b00});
      if (width_vld[2]) begin v2++; w2 = width_out[23:16]; end
      if (width_vld[3]) begin v3++; w3 = width_out[31:24]; end
      nchk++;
      if ({clean, rise, fall, width_vld, width_out} !== exp_vec()) begin
        nfail++;
        $display("FAIL saturate cyc %0d: got %h required %h", n, {clean, rise, fall, width_vld, width_out}, exp_vec());
      end
    end
    nchk += 2;
    if (v2 != 1 || w2 !== 8'd255) begin
      nfail++;
      $display("FAIL saturate_ch2: got vld=%0d width=%0d required 1 255", v2, w2);
    end
    if (v3 != 1 || w3 !== 8'd10) begin
      nfail++;
      $display("FAIL saturate_ch3: got vld=%0d width=%0d required 1 10", v3, w3);
    end
  endtask

  task automatic test_reset_mid();
    int nf = 0, back = -1;
    for (int n = 0; n < 8 + LAT; n++) step(4'b0001);
    nchk++;
    if (clean[0] !== 1'b1) begin
      nfail++;
      $display("FAIL rstmid_pre: got clean0=%b required 1", clean[0]);
    end
    #2 rst = 1;
    #1;
    nchk++;
    if (clean[0] !== 1'b0 || fall[0] !== 1'b0) begin
      nfail++;
      $display("FAIL rstmid_async: got clean0=%b fall0=%b required 0 0", clean[0], fall[0]);
    end
    model_reset();
    step(4'b0001);
    step(4'b0001);
    rst = 0;
    for (int n = 0; n < 14; n++) begin
      step(4'b0001);
      nf += int'(fall[0] | width_vld[0]);
      if (clean[0] && back < 0) back = n + 1;
      nchk++;
      if ({clean, rise, fall, width_vld, width_out} !== exp_vec()) begin
        nfail++;
        $display("FAIL rstmid cyc %0d: got %h required %h", n, {clean, rise, fall, width_vld, width_out}, exp_vec());
      end
    end
    nchk++;
    if (nf != 0 || back != 6 + LAT) begin
      nfail++;
      $display("FAIL rstmid_summary: got falls=%0d requal=%0d required 0 %0d", nf, back, 6 + LAT);
    end
    for (int n = 0; n < 10; n++) step(4'b0000);
  endtask

  task automatic test_random();
    int left [CH];
    logic [CH-1:0] v = '0;
    for (int i = 0; i < CH; i++) left[i] = 1;
    for (int n = 0; n < 3000; n++) begin
      for (int i = 0; i < CH; i++) begin
        left[i]--;
        if (left[i] == 0) begin
          v[i] = ~v[i];
          left[i] = ($urandom_range(0, 7) == 0) ? int'($urandom_range(15, 40)) : int'($urandom_range(1, 12));
        end
      end
      step(v);
      nchk++;
      if ({clean, rise, fall, width_vld, width_out} !== exp_vec()) begin
        nfail++;
        $display("FAIL random cyc %0d: got %h required %h", n, {clean, rise, fall, width_vld, width_out}, exp_vec());
      end
    end
  endtask

  initial begin
    test_reset();
    test_short();
    test_pulse();
    test_glitch();
    test_saturate();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", nchk, nfail);
    $finish;
  end
endmodule
